// File: rtl/noun_walker_dsw_if.sv
// rtl/noun_walker_dsw_if.sv - memory bus and visit handshake between the walker and its memory/execute side
interface noun_walker_dsw_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              visit_valid;
  logic [ADDR_W-1:0] visit_addr;
  logic [DATA_W-1:0] visit_data;
  logic              visit_done;
  logic              bus_grant;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata,
    output visit_valid, visit_addr, visit_data, bus_grant,
    input  visit_done
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata,
    input  visit_valid, visit_addr, visit_data, bus_grant,
    output visit_done
  );
endinterface

// File: rtl/noun_walker_dsw.sv
// rtl/noun_walker_dsw.sv - pointer-reversal (Deutsch-Schorr-Waite) noun tree walker with execute hand-off
module noun_walker_dsw #(
  parameter int                ADDR_W    = 10,
  parameter int                NOUN_W    = 28,
  parameter int                TAG_W     = 8,
  parameter int                DATA_W    = TAG_W + 2*NOUN_W,
  parameter logic [ADDR_W-1:0] NIL       = {ADDR_W{1'b1}},
  parameter int                MAX_DEPTH = 255,
  parameter int                DEPTH_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [ADDR_W-1:0]   i_root_addr,
  output logic                o_busy,
  output logic                o_done,
  output logic [1:0]          o_error,
  output logic [DEPTH_W-1:0]  o_node_count,
  noun_walker_dsw_if.master   bus
);

  localparam int TAG_LO = 2*NOUN_W;
  localparam int HED_LO = NOUN_W;
  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_FETCH_WAIT, S_DECIDE, S_WRITE,
    S_WRITE_WAIT, S_VISIT, S_DONE, S_ERROR
  } state_t;

  state_t              r_state, n_state;
  logic [ADDR_W-1:0]   r_p, n_p;
  logic [ADDR_W-1:0]   r_b, n_b;
  logic [ADDR_W-1:0]   r_waddr, n_waddr;
  logic [DEPTH_W-1:0]  r_depth, n_depth;
  logic [DEPTH_W-1:0]  r_count, n_count;
  logic [DATA_W-1:0]   r_word, n_word;
  logic                r_pop, n_pop;
  logic [1:0]          r_error, n_error;

  logic                w_hc, w_tc, w_hv, w_tv, w_exec;
  logic [ADDR_W-1:0]   w_hed_ptr, w_tel_ptr;
  logic                w_at_max;
  logic                w_do_cont;
  logic [ADDR_W-1:0]   w_back;

  assign w_hc      = r_word[TAG_LO+1];
  assign w_tc      = r_word[TAG_LO+0];
  assign w_hv      = r_word[TAG_LO+3];
  assign w_tv      = r_word[TAG_LO+2];
  assign w_exec    = r_word[TAG_LO+7];
  assign w_hed_ptr = r_word[HED_LO +: ADDR_W];
  assign w_tel_ptr = r_word[0 +: ADDR_W];
  assign w_at_max  = (r_depth == MAX_D);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_b     <= NIL;
      r_waddr <= '0;
      r_depth <= '0;
      r_count <= '0;
      r_word  <= '0;
      r_pop   <= 1'b0;
      r_error <= 2'd0;
    end else begin
      r_state <= n_state;
      r_p     <= n_p;
      r_b     <= n_b;
      r_waddr <= n_waddr;
      r_depth <= n_depth;
      r_count <= n_count;
      r_word  <= n_word;
      r_pop   <= n_pop;
      r_error <= n_error;
    end
  end

  always_comb begin
    n_state   = r_state;
    n_p       = r_p;
    n_b       = r_b;
    n_waddr   = r_waddr;
    n_depth   = r_depth;
    n_count   = r_count;
    n_word    = r_word;
    n_pop     = r_pop;
    n_error   = r_error;
    w_do_cont = 1'b0;
    w_back    = r_b;

    case (r_state)
      S_IDLE, S_ERROR: begin
        if (i_start) begin
          if (i_root_addr == NIL) begin
            n_error = 2'd2;
            n_state = S_ERROR;
          end else begin
            n_error = 2'd0;
            n_p     = i_root_addr;
            n_b     = NIL;
            n_depth = '0;
            n_count = '0;
            n_state = S_FETCH;
          end
        end
      end
      S_FETCH: n_state = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        if (bus.mem_ready) begin
          n_word  = bus.mem_rdata;
          n_state = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (!w_hv && !w_tv && (w_hc || w_tc) && (r_count != '1))
          n_count = r_count + DEPTH_W'(1);
        if (w_hc && !w_hv) begin
          if (w_at_max) begin
            n_error = 2'd1;
            n_state = S_ERROR;
          end else begin
            n_word[HED_LO +: ADDR_W] = r_b;
            n_word[TAG_LO+3]         = 1'b1;
            n_b     = r_p;
            n_p     = w_hed_ptr;
            n_waddr = r_p;
            n_depth = r_depth + DEPTH_W'(1);
            n_pop   = 1'b0;
            n_state = S_WRITE;
          end
        end else if (w_tc && !w_tv) begin
          if (w_at_max) begin
            n_error = 2'd1;
            n_state = S_ERROR;
          end else begin
            // Returning from the hed child: put it back and recover our parent link in the same step.
            if (w_hv) begin
              n_word[HED_LO +: ADDR_W] = r_b;
              w_back = w_hed_ptr;
            end
            n_word[0 +: ADDR_W] = w_back;
            n_word[TAG_LO+2]    = 1'b1;
            n_b     = r_p;
            n_p     = w_tel_ptr;
            n_waddr = r_p;
            n_depth = r_depth + DEPTH_W'(1);
            n_pop   = 1'b0;
            n_state = S_WRITE;
          end
        end else if (w_tv || w_hv) begin
          if (w_tv) begin
            n_word[0 +: ADDR_W] = r_b;
            n_b = w_tel_ptr;
          end else begin
            n_word[HED_LO +: ADDR_W] = r_b;
            n_b = w_hed_ptr;
          end
          n_word[TAG_LO+3] = 1'b0;
          n_word[TAG_LO+2] = 1'b0;
          n_waddr = r_p;
          n_pop   = 1'b1;
          n_state = S_WRITE;
        end else if (w_exec) begin
          n_state = S_VISIT;
        end else begin
          w_do_cont = 1'b1;
        end
      end
      S_WRITE: n_state = S_WRITE_WAIT;
      S_WRITE_WAIT: begin
        if (bus.mem_ready) begin
          if (!r_pop)
            n_state = S_FETCH;
          else if (w_exec)
            n_state = S_VISIT;
          else
            w_do_cont = 1'b1;
        end
      end
      S_VISIT: begin
        if (bus.visit_done)
          w_do_cont = 1'b1;
      end
      S_DONE:  n_state = S_IDLE;
      default: n_state = S_IDLE;
    endcase

    // After a pop P is the finished node and B its parent; climbing swaps them.
    if (w_do_cont) begin
      if (r_b == NIL) begin
        n_state = S_DONE;
      end else begin
        n_p     = r_b;
        n_b     = r_p;
        n_depth = r_depth - DEPTH_W'(1);
        n_state = S_FETCH;
      end
    end
  end

  assign o_busy       = !(r_state inside {S_IDLE, S_DONE, S_ERROR});
  assign o_done       = (r_state == S_DONE);
  assign o_error      = r_error;
  assign o_node_count = r_count;

  assign bus.mem_req     = (r_state == S_FETCH) || (r_state == S_WRITE);
  assign bus.mem_we      = (r_state == S_WRITE);
  assign bus.mem_addr    = (r_state == S_FETCH) ? r_p :
                           (r_state == S_WRITE) ? r_waddr : '0;
  assign bus.mem_wdata   = (r_state == S_WRITE) ? r_word : '0;
  assign bus.visit_valid = (r_state == S_VISIT);
  assign bus.bus_grant   = (r_state == S_VISIT);
  assign bus.visit_addr  = (r_state == S_VISIT) ? r_p : '0;
  assign bus.visit_data  = (r_state == S_VISIT) ? r_word : '0;

endmodule

// File: tb/tb_noun_walker_dsw.sv
// tb/tb_noun_walker_dsw.sv - scoreboard bench for noun_walker_dsw
module tb_noun_walker_dsw;
  localparam logic [9:0] NIL = 10'h3FF;
  localparam int EV_READ = 0, EV_VISIT = 1, EV_DONE = 2, EV_ERR = 3;

  typedef struct {
    int          kind;
    logic [9:0]  addr;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  root_addr = '0;
  logic        busy, done;
  logic [1:0]  err;
  logic [7:0]  cnt;

  noun_walker_dsw_if #(.ADDR_W(10), .DATA_W(64)) bus ();

  noun_walker_dsw #(.MAX_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_root_addr  (root_addr),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (err),
    .o_node_count (cnt),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [0:1023];
  exp_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_reads = 0;
  int          n_writes = 0;
  int          cyc = 0;
  int          last_ready_cyc = 0;
  int          lat = 0;
  int          vcnt = 0;
  logic [9:0]  pa;
  logic        pwe;
  logic [63:0] pwd;
  logic        prev_vv = 1'b0;
  logic [1:0]  prev_err = 2'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mkw(input logic [7:0] t, input logic [27:0] h, input logic [27:0] l);
    return {t, h, l};
  endfunction

  task automatic expect_ev(input int k, input logic [9:0] a, input logic [63:0] d);
    exp_t e;
    e.kind = k; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic take(input int kind, output exp_t e, output bit ok);
    if (q.size() == 0) begin
      e.kind = -1; e.addr = '0; e.data = '0;
    end else begin
      e = q.pop_front();
    end
    check("event kind", 64'(kind), 64'(e.kind));
    ok = (e.kind == kind);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: one outstanding request, ready two falling edges after the request is seen.
  always @(negedge clk) begin
    bus.mem_ready = 1'b0;
    if (!rst) begin
      lat = 0;
    end else if (lat > 0) begin
      lat--;
      if (lat == 0) begin
        bus.mem_ready = 1'b1;
        last_ready_cyc = cyc;
        if (pwe) mem[pa] = pwd;
        else     bus.mem_rdata = mem[pa];
      end
    end else if (bus.mem_req) begin
      pa = bus.mem_addr; pwe = bus.mem_we; pwd = bus.mem_wdata; lat = 2;
      if (pwe) n_writes++; else n_reads++;
    end
  end

  // Execute module: holds the node for 10 cycles.
  always @(negedge clk) begin
    bus.visit_done = 1'b0;
    if (rst && bus.visit_valid) begin
      vcnt++;
      if (vcnt == 10) begin
        bus.visit_done = 1'b1;
        vcnt = 0;
      end
    end else begin
      vcnt = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (rst) begin
      if (bus.mem_req && !bus.mem_we) begin
        take(EV_READ, e, ok);
        if (ok) check("read addr", 64'(bus.mem_addr), 64'(e.addr));
      end
      if (bus.visit_valid && !prev_vv) begin
        take(EV_VISIT, e, ok);
        if (ok) begin
          check("visit addr", 64'(bus.visit_addr), 64'(e.addr));
          check("visit data", bus.visit_data, e.data);
          check("bus grant", 64'(bus.bus_grant), 64'd1);
        end
      end
      if (done) begin
        take(EV_DONE, e, ok);
        if (ok) begin
          check("done count", 64'(cnt), 64'(e.addr));
          check("done error", 64'(err), 64'd0);
          if (e.data[0]) check("done latency ok", 64'((cyc - last_ready_cyc) <= 2), 64'd1);
        end
      end
      if (err != 2'd0 && err != prev_err) begin
        take(EV_ERR, e, ok);
        if (ok) begin
          check("error code", 64'(err), 64'(e.addr));
          check("error count", 64'(cnt), e.data);
          check("busy at error", 64'(busy), 64'd0);
        end
      end
      prev_vv  = bus.visit_valid;
      prev_err = err;
    end else begin
      prev_vv  = 1'b0;
      prev_err = 2'd0;
    end
  end

  task automatic pulse_start(input logic [9:0] r);
    @(negedge clk);
    root_addr = r;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_run(input string name);
    int i;
    for (i = 0; i < 500 && busy; i++) @(negedge clk);
    check({name, " timeout"}, 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check({name, " events pending"}, 64'(q.size()), 64'd0);
  endtask

  task automatic init_tree(input logic [7:0] t6);
    mem[5] = mkw(8'h43, 28'h5500006, 28'h6600007);
    mem[6] = mkw(t6,    28'h0123456, 28'h0789ABC);
    mem[7] = mkw(8'h30, 28'hFEDCBA9, 28'h1111111);
  endtask

  task automatic expect_tree(input bit with_visit);
    expect_ev(EV_READ, 10'd5, '0);
    expect_ev(EV_READ, 10'd6, '0);
    if (with_visit) expect_ev(EV_VISIT, 10'd6, mkw(8'h80, 28'h0123456, 28'h0789ABC));
    expect_ev(EV_READ, 10'd5, '0);
    expect_ev(EV_READ, 10'd7, '0);
    expect_ev(EV_READ, 10'd5, '0);
    expect_ev(EV_DONE, 10'd1, '0);
  endtask

  task automatic check_tree(input string name, input logic [7:0] t6);
    check({name, " mem5"}, mem[5], mkw(8'h43, 28'h5500006, 28'h6600007));
    check({name, " mem6"}, mem[6], mkw(t6,    28'h0123456, 28'h0789ABC));
    check({name, " mem7"}, mem[7], mkw(8'h30, 28'hFEDCBA9, 28'h1111111));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int r0, w0, i;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    bus.visit_done = 1'b0;
    for (i = 0; i < 1024; i++) mem[i] = '0;

    repeat (3) @(negedge clk);
    check("reset outputs", {busy, done, err, cnt, bus.mem_req, bus.visit_valid, bus.bus_grant},
          64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single atom-atom root
    mem[5] = mkw(8'h00, 28'hABCDE12, 28'h0000123);
    r0 = n_reads; w0 = n_writes;
    expect_ev(EV_READ, 10'd5, '0);
    expect_ev(EV_DONE, 10'd0, 64'd1);
    pulse_start(10'd5);
    finish_run("atom root");
    check("atom reads", 64'(n_reads - r0), 64'd1);
    check("atom writes", 64'(n_writes - w0), 64'd0);

    // Three-node tree
    init_tree(8'h00);
    w0 = n_writes;
    expect_tree(1'b0);
    pulse_start(10'd5);
    finish_run("tree");
    check("tree writes", 64'(n_writes - w0), 64'd3);
    check_tree("tree", 8'h00);

    // Same tree, execute flag on node 6
    init_tree(8'h80);
    expect_tree(1'b1);
    pulse_start(10'd5);
    finish_run("visit tree");
    check_tree("visit tree", 8'h80);

    // Left chain deeper than MAX_DEPTH
    mem[20] = mkw(8'h02, 28'h0000015, 28'h0);
    mem[21] = mkw(8'h02, 28'h0000016, 28'h0);
    mem[22] = mkw(8'h02, 28'h0000017, 28'h0);
    mem[23] = mkw(8'h00, 28'h0,       28'h0);
    w0 = n_writes;
    expect_ev(EV_READ, 10'd20, '0);
    expect_ev(EV_READ, 10'd21, '0);
    expect_ev(EV_READ, 10'd22, '0);
    expect_ev(EV_ERR, 10'd1, 64'd3);
    pulse_start(10'd20);
    finish_run("depth overflow");
    check("overflow writes", 64'(n_writes - w0), 64'd2);
    check("overflow error held", 64'(err), 64'd1);

    // NIL root, restarted from ERROR
    r0 = n_reads;
    expect_ev(EV_ERR, 10'd2, 64'd3);
    pulse_start(NIL);
    finish_run("nil root");
    check("nil reads", 64'(n_reads - r0), 64'd0);

    // Reset during the first WRITE_WAIT, then a clean walk
    init_tree(8'h00);
    expect_ev(EV_READ, 10'd5, '0);
    pulse_start(10'd5);
    for (i = 0; i < 50 && !(bus.mem_req && bus.mem_we); i++) @(negedge clk);
    check("write reached", 64'(bus.mem_req && bus.mem_we), 64'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async reset outputs", {busy, done, err, bus.mem_req, bus.mem_we, bus.visit_valid,
          bus.bus_grant, bus.mem_addr}, 64'd0);
    check("async reset count", 64'(cnt), 64'd0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    expect_tree(1'b0);
    pulse_start(10'd5);
    finish_run("after reset");
    check_tree("after reset", 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
